angle_sweep: RTL

Beam-steering sweep controller that produces the `angle`/`wbdone` pair consumed by the 7-segment angle display. On `start` it steps a steering angle from ANG_MIN to ANG_MAX in ANG_STEP increments and requests one power measurement per angle from the beamformer power accumulator over a req/ack handshake. It tracks the angle with the largest power and, at sweep end, presents that angle with a one-cycle `wbdone` pulse.

---
 rtl/angle_pkg.sv | 25 ++
 rtl/argmax_tracker.sv | 56 +++++
 rtl/angle_sweep.sv | 118 +++++++++++
 3 files changed

// File: rtl/angle_pkg.sv
// Shared angle type, sweep state encoding and default sweep range for the
// beam-steering sweep, the angle display and the beamformer.
package angle_pkg;

  localparam int unsigned ANG_W = 8;

  typedef logic signed [ANG_W-1:0] angle_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_NEXT = 2'd2,
    S_DONE = 2'd3
  } sweep_state_e;

  localparam int ANG_MIN_DEF  = -90;
  localparam int ANG_MAX_DEF  = 90;
  localparam int ANG_STEP_DEF = 5;

  // True when an angle fits the signed 8-bit steering range.
  function automatic bit ang_in_range(input int a);
    return (a >= -128) && (a <= 127);
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Tracks the angle with the largest power seen since the last clear.
// Ties keep the earlier angle; the first load after a clear always wins.
module argmax_tracker
  import angle_pkg::*;
#(
  parameter int unsigned PWR_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [PWR_W-1:0] power_i,
  input  angle_t           ang_i,
  output angle_t           best_ang_c
);

  logic             first_q,    first_d;
  logic [PWR_W-1:0] best_pwr_q, best_pwr_d;
  angle_t           best_ang_q, best_ang_d;
  logic             take_c;

  // Strict unsigned compare so an equal power never displaces an earlier angle.
  always_comb begin
    take_c     = first_q || (power_i > best_pwr_q);
    first_d    = first_q;
    best_pwr_d = best_pwr_q;
    best_ang_d = best_ang_q;
    if (clear_i) begin
      first_d    = 1'b1;
      best_pwr_d = '0;
      best_ang_d = '0;
    end else if (load_i) begin
      first_d = 1'b0;
      if (take_c) begin
        best_pwr_d = power_i;
        best_ang_d = ang_i;
      end
    end
  end

  // Updated best angle, visible in the same cycle as the load.
  assign best_ang_c = (load_i && take_c) ? ang_i : best_ang_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      first_q    <= 1'b0;
      best_pwr_q <= '0;
      best_ang_q <= '0;
    end else begin
      first_q    <= first_d;
      best_pwr_q <= best_pwr_d;
      best_ang_q <= best_ang_d;
    end
  end

endmodule

// File: rtl/angle_sweep.sv
// Beam-steering sweep controller: steps the steering angle across the range,
// requests one power measurement per angle and reports the loudest angle.
module angle_sweep
  import angle_pkg::*;
#(
  parameter int          ANG_MIN  = ANG_MIN_DEF,
  parameter int          ANG_MAX  = ANG_MAX_DEF,
  parameter int          ANG_STEP = ANG_STEP_DEF,
  parameter int unsigned PWR_W    = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic signed [7:0] steer_angle,
  output logic             steer_req,
  input  logic             steer_ack,
  input  logic [PWR_W-1:0] power,
  output logic signed [7:0] angle,
  output logic             wbdone,
  output logic             busy
);

  localparam int     STEP_SAFE = (ANG_STEP > 0) ? ANG_STEP : 1;
  localparam angle_t MIN_A     = angle_t'(ANG_MIN);
  localparam angle_t MAX_A     = angle_t'(ANG_MAX);
  localparam angle_t STEP_A    = angle_t'(STEP_SAFE);

  // Reject parameter sets the 8-bit angle counter cannot walk exactly.
  if (!(ang_in_range(ANG_MIN) && ang_in_range(ANG_MAX) && (ANG_STEP > 0) &&
        ang_in_range(ANG_STEP) && (ANG_MAX >= ANG_MIN) &&
        (((ANG_MAX - ANG_MIN) % STEP_SAFE) == 0))) begin : g_param_check
    $error("angle_sweep: illegal ANG_MIN/ANG_MAX/ANG_STEP combination");
  end

  sweep_state_e state_q, state_d;
  angle_t       steer_angle_q, steer_angle_d;
  angle_t       angle_q, angle_d;
  logic         steer_req_q, wbdone_q, busy_q;
  logic         clear_c, load_c;
  angle_t       best_ang_c;

  argmax_tracker #(
    .PWR_W (PWR_W)
  ) u_argmax (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear_i    (clear_c),
    .load_i     (load_c),
    .power_i    (power),
    .ang_i      (steer_angle_q),
    .best_ang_c (best_ang_c)
  );

  // Next-state, angle counter and result capture.
  always_comb begin
    state_d       = state_q;
    steer_angle_d = steer_angle_q;
    angle_d       = angle_q;
    clear_c       = 1'b0;
    load_c        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          steer_angle_d = MIN_A;
          clear_c       = 1'b1;
          state_d       = S_REQ;
        end
      end
      S_REQ: begin
        if (steer_ack) begin
          load_c = 1'b1;
          if (steer_angle_q == MAX_A) begin
            angle_d = best_ang_c;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end
      S_NEXT: begin
        steer_angle_d = steer_angle_q + STEP_A;
        state_d       = S_REQ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      steer_angle_q <= '0;
      angle_q       <= '0;
      steer_req_q   <= 1'b0;
      wbdone_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      steer_angle_q <= steer_angle_d;
      angle_q       <= angle_d;
      steer_req_q   <= (state_d == S_REQ);
      wbdone_q      <= (state_d == S_DONE);
      busy_q        <= (state_d != S_IDLE);
    end
  end

  assign steer_angle = steer_angle_q;
  assign steer_req   = steer_req_q;
  assign angle       = angle_q;
  assign wbdone      = wbdone_q;
  assign busy        = busy_q;

endmodule
